// File: rtl/outer_prod_ctl_pkg.sv
// outer_prod_ctl_pkg: shared latency constant, sequencer state and period helper.
// Used by outer_prod_ctl and opc_coef_bank.
package outer_prod_ctl_pkg;

    localparam int LAT = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Interval never shorter than one full result window.
    function automatic int peff_f(input int period, input int nelem);
        int floor_p;
        floor_p = nelem + LAT;
        return (period > floor_p) ? period : floor_p;
    endfunction

endpackage

// File: rtl/opc_coef_bank.sv
// opc_coef_bank: two-bank coefficient RAM.
// One write port and one registered read port, each with its own bank select.
module opc_coef_bank
    import outer_prod_ctl_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          wbank,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rbank,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**(AW+1)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wbank, waddr}] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[{rbank, raddr}];
        end
    end

endmodule

// File: rtl/outer_prod_ctl.sv
// outer_prod_ctl: start sequencer, double-buffered coefficient server, result tagger.
// Optional OUTER_PROD_CTL_CLAMP_EN keeps stored coefficients off full-scale negative.
module outer_prod_ctl
    import outer_prod_ctl_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DW    = 18,
    parameter int NELEM = 16,
    parameter int PW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [PW-1:0] period,
    input  logic          lb_we,
    input  logic [AW-1:0] lb_addr,
    input  logic [DW-1:0] lb_data,
    input  logic          lb_swap,
    output logic          start,
    input  logic [AW-1:0] k_out_addr,
    output logic [DW-1:0] k_out,
    input  logic [DW-1:0] result,
    output logic          res_valid,
    output logic [AW-1:0] res_idx,
    output logic [DW-1:0] res_data,
    output logic          swap_pend,
    output logic          swap_done,
    output logic          active_bank
);

    localparam int PHW = $clog2(LAT + NELEM + 1);
    localparam logic [PHW-1:0] PH_FIRST = PHW'(LAT - 1);
    localparam logic [PHW-1:0] PH_LAST  = PHW'(LAT + NELEM - 2);

    state_t          state;
    logic [PW-1:0]   cnt;
    logic            launch;
    logic            bank_r;
    logic            pend_r;
    logic            commit;
    logic            running;
    logic [PHW-1:0]  ph;
    logic            valid_nxt;
    logic [DW-1:0]   wdata;

    // The swap lands in the start cycle itself, so the whole frame sees one bank.
    assign commit      = start & (pend_r | lb_swap);
    assign active_bank = bank_r ^ commit;
    assign swap_done   = commit;
    assign swap_pend   = pend_r & ~start;

`ifdef OUTER_PROD_CTL_CLAMP_EN
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    assign wdata = (lb_data == MIN_NEG) ? MIN_NEG + 1'b1 : lb_data;
`else
    assign wdata = lb_data;
`endif

    always_comb begin
        launch = 1'b0;
        unique case (state)
            IDLE:    launch = enable;
            RUN:     launch = enable & ~start & (cnt == PW'(1));
            default: launch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            start <= 1'b0;
            cnt   <= '0;
        end else begin
            start <= launch;
            if (start) begin
                cnt <= PW'(peff_f(int'(period), NELEM) - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            unique case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= DRAIN;
                DRAIN:   if (!running && !res_valid && !start) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_r <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            bank_r <= active_bank;
            pend_r <= ~commit & (pend_r | lb_swap);
        end
    end

    assign valid_nxt = running & ~start
                     & (ph >= PH_FIRST) & (ph <= PH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= 1'b0;
            ph        <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
        end else begin
            res_data  <= result;
            res_valid <= valid_nxt;
            res_idx   <= valid_nxt ? AW'(ph - PH_FIRST) : '0;
            if (start) begin
                running <= 1'b1;
                ph      <= PHW'(1);
            end else if (running) begin
                ph <= ph + 1'b1;
                if (ph == PH_LAST) running <= 1'b0;
            end
        end
    end

    opc_coef_bank #(
        .AW (AW),
        .DW (DW)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lb_we),
        .wbank (~active_bank),
        .waddr (lb_addr),
        .wdata (wdata),
        .rbank (active_bank),
        .raddr (k_out_addr),
        .rdata (k_out)
    );

endmodule

// File: tb/tb_outer_prod_ctl.sv
// tb_outer_prod_ctl: scoreboard bench with a behavioural outer_prod stand-in.
// Honours OUTER_PROD_CTL_CLAMP_EN for the clamp expectation.
module tb_outer_prod_ctl;
    import outer_prod_ctl_pkg::*;

    localparam int AW = 10;
    localparam int DW = 18;
    localparam int NELEM = 16;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] period = 16'd40;
    logic          lb_we = 1'b0;
    logic [AW-1:0] lb_addr = '0;
    logic [DW-1:0] lb_data = '0;
    logic          lb_swap = 1'b0;
    logic          start;
    logic [AW-1:0] k_out_addr = '0;
    logic [DW-1:0] k_out;
    logic [DW-1:0] result = '0;
    logic          res_valid;
    logic [AW-1:0] res_idx;
    logic [DW-1:0] res_data;
    logic          swap_pend;
    logic          swap_done;
    logic          active_bank;

    outer_prod_ctl #(
        .AW(AW), .DW(DW), .NELEM(NELEM), .PW(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
        .lb_swap(lb_swap), .start(start), .k_out_addr(k_out_addr),
        .k_out(k_out), .result(result), .res_valid(res_valid),
        .res_idx(res_idx), .res_data(res_data), .swap_pend(swap_pend),
        .swap_done(swap_done), .active_bank(active_bank)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // outer_prod stand-in: element i fetched one cycle after start + i,
    // result presented four cycles after its coefficient arrives.
    int     since = 1000;
    longint xval = 65536;
    logic signed [DW-1:0] hist [5];

    always @(posedge clk) begin
        #1;
        if (start) since = 0;
        else if (since < 1000) since++;
        for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = k_out;
        k_out_addr = (since >= 1 && since <= NELEM) ? AW'(since - 1) : '0;
        result = DW'((longint'(hist[4]) * xval) >>> 17);
    end

    typedef struct {
        longint cyc;
        longint idx;
        logic signed [63:0] data;
    } exp_t;

    exp_t   q[$];
    exp_t   e;
    longint cyc = 0;
    longint prev_cyc = 0;
    int     gap_exp = 0;
    bit     have_prev = 0;
    int     nstart = 0;
    logic   m_bank = 1'b0;
    logic   m_pend = 1'b0;
    logic   m_commit;
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] kb [2][NELEM];
`ifdef OUTER_PROD_CTL_CLAMP_EN
    localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
`endif

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_bank = 1'b0;
            m_pend = 1'b0;
            have_prev = 0;
        end else begin
            m_commit = start && (m_pend || lb_swap);
            chk("swap_done", swap_done, m_commit);
            chk("swap_pend", swap_pend, m_pend && !start);
            if (m_commit) begin
                m_bank = ~m_bank;
                m_pend = 1'b0;
            end else if (lb_swap) begin
                m_pend = 1'b1;
            end
            chk("active_bank", active_bank, m_bank);
            if (lb_we && lb_addr < AW'(NELEM)) begin
                d = lb_data;
`ifdef OUTER_PROD_CTL_CLAMP_EN
                if (d == MINV) d = MINV + 1;
`endif
                kb[~m_bank][lb_addr] = d;
            end
            if (start) begin
                nstart++;
                if (have_prev) chk("gap", cyc - prev_cyc, gap_exp);
                prev_cyc = cyc;
                have_prev = 1;
                gap_exp = (int'(period) > NELEM + LAT) ? int'(period) : NELEM + LAT;
                for (int i = 0; i < NELEM; i++) begin
                    e.cyc = cyc + LAT + i;
                    e.idx = i;
                    d = DW'((longint'(kb[m_bank][i]) * xval) >>> 17);
                    e.data = d;
                    q.push_back(e);
                end
            end
            if (!enable) have_prev = 0;
            if (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_valid", 0, 1);
                void'(q.pop_front());
            end
            if (res_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("res_idx", res_idx, e.idx);
                    chk("res_data", $signed(res_data), e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int v);
        lb_we = 1'b1;
        lb_addr = AW'(a);
        lb_data = DW'(v);
        tick();
        lb_we = 1'b0;
    endtask

    task automatic swap();
        lb_swap = 1'b1;
        tick();
        lb_swap = 1'b0;
    endtask

    task automatic wait_next_start(input int max);
        int n;
        n = 0;
        tick();
        while (!start && n < max) begin
            tick();
            n++;
        end
        if (!start) chk("start_timeout", 0, 1);
    endtask

    initial begin
        int n0;
        int n;
        repeat (3) tick();
        chk("rst_start", start, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_idx", res_idx, 0);
        chk("rst_data", res_data, 0);
        chk("rst_kout", k_out, 0);
        chk("rst_bank", active_bank, 0);
        chk("rst_pend", swap_pend, 0);
        chk("rst_done", swap_done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_start", start, 0);
            chk("idle_valid", res_valid, 0);
        end

        for (int i = 0; i < NELEM; i++) wr(i, 1000);
        swap();
        chk("pend_idle", swap_pend, 1);
        period = 16'd40;
        enable = 1'b1;
        wait_next_start(5);
        chk("first_commit", active_bank, 1);
        repeat (2) wait_next_start(60);

        for (int i = 0; i < NELEM; i++) wr(i, -2000);
        swap();
        chk("pend_mid", swap_pend, 1);
        period = 16'd5;
        wait_next_start(60);
        chk("commit_pend", swap_pend, 0);
        chk("commit_done", swap_done, 1);
        repeat (3) wait_next_start(60);

        wait_next_start(60);
        lb_swap = 1'b1;
        lb_we = 1'b1;
        lb_addr = AW'(3);
        lb_data = DW'(777);
        tick();
        lb_swap = 1'b0;
        lb_we = 1'b0;
        repeat (5) tick();
        swap();
        repeat (2) wait_next_start(60);

        wr(5, -131072);
        swap();
        wait_next_start(60);
        xval = 131072;
        repeat (2) wait_next_start(60);

        wait_next_start(60);
        enable = 1'b0;
        tick();
        n0 = nstart;
        repeat (59) tick();
        chk("drain_starts", nstart - n0, 0);
        chk("drain_queue", q.size(), 0);
        enable = 1'b1;
        wait_next_start(4);
        repeat (3) tick();
        swap();

        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk("mr_saw_valid", res_valid, 1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mr_valid", res_valid, 0);
        chk("mr_start", start, 0);
        chk("mr_pend", swap_pend, 0);
        chk("mr_bank", active_bank, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_next_start(5);
        chk("mr_restart_bank", active_bank, 0);
        repeat (30) tick();
        enable = 1'b0;
        repeat (30) tick();
        chk("end_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
